// File: rtl/mem_arb_pkg.sv
// Shared types for the memory refill arbiter: FSM states, owner encoding and
// default burst geometry.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  localparam int BURST_LEN_DEF   = 4;
  localparam int WORD_OFFSET_DEF = 2;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick between the icache and dcache refill requests.
// A lone request always wins; on a tie the side that was not granted last wins.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_ic,
  input  logic   req_dc,
  input  owner_t last_grant,
  output logic   valid,
  output owner_t winner
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    valid  = req_ic | req_dc;
    winner = OWN_IC;
    if (req_ic && req_dc) begin
      winner = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
    end else if (req_dc) begin
      winner = OWN_DC;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one memory refill port between icache and dcache, one full burst per grant.
// Optional beat timeout with abort pulse: define MEM_ARB_TIMEOUT_EN.
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int WORD_OFFSET = WORD_OFFSET_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_ic2arb,
  input  logic [ADR_WIDTH-1:0]   adr_ic2arb,
  output logic                   ack_arb2ic,
  output logic [DATA_WIDTH-1:0]  dat_arb2ic,
  output logic                   err_arb2ic,
  input  logic                   req_dc2arb,
  input  logic [ADR_WIDTH-1:0]   adr_dc2arb,
  output logic                   ack_arb2dc,
  output logic [DATA_WIDTH-1:0]  dat_arb2dc,
  output logic                   err_arb2dc,
  output logic [WORD_OFFSET-1:0] word_arb2cc,
  output logic                   req_arb2mem,
  output logic [ADR_WIDTH-1:0]   adr_arb2mem,
  input  logic                   ack_mem2arb,
  input  logic [DATA_WIDTH-1:0]  dat_mem2arb,
  output logic                   busy
);

  arb_state_t             state;
  owner_t                 owner;
  owner_t                 last_grant;
  logic [WORD_OFFSET-1:0] beat;
  logic                   pick_valid;
  owner_t                 pick;
  logic                   route;
  logic                   last_beat;
  logic                   tmo_hit;

  mem_arb_rr2 u_rr (
    .req_ic     (req_ic2arb),
    .req_dc     (req_dc2arb),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick)
  );

  // Memory acks only count while a burst owns the port; elsewhere they are dropped.
  assign route     = (state == BURST) && ack_mem2arb;
  assign last_beat = route && (beat == WORD_OFFSET'(BURST_LEN - 1));

  assign ack_arb2ic  = route && (owner == OWN_IC);
  assign ack_arb2dc  = route && (owner == OWN_DC);
  assign dat_arb2ic  = ack_arb2ic ? dat_mem2arb : '0;
  assign dat_arb2dc  = ack_arb2dc ? dat_mem2arb : '0;
  assign word_arb2cc = route ? beat : '0;
  assign busy        = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // tmo_cnt holds cycles elapsed since the grant or last ack, so the abort
  // pulse lands exactly TIMEOUT_CYC cycles after that event.
  assign tmo_hit    = (state == BURST) && !ack_mem2arb && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign err_arb2ic = err_q && (owner == OWN_IC);
  assign err_arb2dc = err_q && (owner == OWN_DC);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state == IDLE || ack_mem2arb) begin
        tmo_cnt <= TW'(1);
      end else if (state == BURST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = 32'(TIMEOUT_CYC);
  assign tmo_hit    = 1'b0;
  assign err_arb2ic = 1'b0;
  assign err_arb2dc = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IC;
      last_grant  <= OWN_DC;
      beat        <= '0;
      req_arb2mem <= 1'b0;
      adr_arb2mem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner       <= pick;
            last_grant  <= pick;
            adr_arb2mem <= (pick == OWN_DC) ? adr_dc2arb : adr_ic2arb;
            req_arb2mem <= 1'b1;
            beat        <= '0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (route) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              beat        <= '0;
              req_arb2mem <= 1'b0;
              state       <= RELEASE;
            end
          end else if (tmo_hit) begin
            beat        <= '0;
            req_arb2mem <= 1'b0;
            state       <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: transaction-level model plus
// directed refill scenarios with hand-computed expectations.
module tb_mem_refill_arbiter;

  localparam int BL  = 4;
  localparam int TMO = 64;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ic = 1'b0, req_dc = 1'b0;
  logic [31:0] adr_ic = '0, adr_dc = '0;
  logic        ack_mem = 1'b0;
  logic [31:0] dat_mem = '0;

  logic        ack_arb2ic, err_arb2ic, ack_arb2dc, err_arb2dc;
  logic [31:0] dat_arb2ic, dat_arb2dc, adr_arb2mem;
  logic [1:0]  word_arb2cc;
  logic        req_arb2mem, busy;

  int checks = 0;
  int errors = 0;

  mem_refill_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_ic2arb  (req_ic),
    .adr_ic2arb  (adr_ic),
    .ack_arb2ic  (ack_arb2ic),
    .dat_arb2ic  (dat_arb2ic),
    .err_arb2ic  (err_arb2ic),
    .req_dc2arb  (req_dc),
    .adr_dc2arb  (adr_dc),
    .ack_arb2dc  (ack_arb2dc),
    .dat_arb2dc  (dat_arb2dc),
    .err_arb2dc  (err_arb2dc),
    .word_arb2cc (word_arb2cc),
    .req_arb2mem (req_arb2mem),
    .adr_arb2mem (adr_arb2mem),
    .ack_mem2arb (ack_mem),
    .dat_mem2arb (dat_mem),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: who owns the port, beats delivered, dead cycles left,
  // and the cycle stamp of the last grant/ack for the timeout.
  int          cyc      = 0;
  bit          m_burst  = 1'b0;
  int          m_dead   = 0;
  int          m_owner  = 0;
  int          m_last   = 1;
  int          m_beats  = 0;
  int          m_evt    = 0;
  bit          m_err    = 1'b0;
  logic [31:0] m_adr    = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_burst = 1'b0;
      m_dead  = 0;
      m_last  = 1;
      m_beats = 0;
      m_adr   = '0;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_burst) begin
        if (ack_mem) begin
          m_beats++;
          m_evt = cyc;
          if (m_beats == BL) begin
            m_burst = 1'b0;
            m_dead  = 1;
          end
        end else if (TMO_EN && (cyc + 1 - m_evt == TMO)) begin
          m_burst = 1'b0;
          m_dead  = 1;
          m_err   = 1'b1;
        end
      end else if (m_dead > 0) begin
        m_dead--;
      end else if (req_ic || req_dc) begin
        if (req_ic && req_dc) m_owner = (m_last == 1) ? 0 : 1;
        else                  m_owner = req_dc ? 1 : 0;
        m_last  = m_owner;
        m_adr   = (m_owner == 1) ? adr_dc : adr_ic;
        m_burst = 1'b1;
        m_beats = 0;
        m_evt   = cyc;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    bit r;
    if (!rst) begin
      r = m_burst && ack_mem;
      check("ctrl", {ack_arb2ic, ack_arb2dc, err_arb2ic, err_arb2dc, word_arb2cc, req_arb2mem, busy},
            {r && (m_owner == 0), r && (m_owner == 1), m_err && (m_owner == 0), m_err && (m_owner == 1),
             r ? 2'(m_beats) : 2'b00, m_burst, m_burst || (m_dead > 0)});
      check("adr", adr_arb2mem, m_adr);
      check("dat_ic", dat_arb2ic, (r && m_owner == 0) ? dat_mem : 32'h0);
      check("dat_dc", dat_arb2dc, (r && m_owner == 1) ? dat_mem : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!req_arb2mem && n < 10) begin
      step();
      n++;
    end
    check(name, req_arb2mem, 1'b1);
  endtask

  // One memory beat in the current cycle, checked at mid-cycle.
  task automatic ack_beat(input logic [31:0] d, input logic [1:0] w, input logic to_ic);
    ack_mem = 1'b1;
    dat_mem = d;
    @(negedge clk);
    check("beat_word", word_arb2cc, w);
    check("beat_dst", {ack_arb2ic, ack_arb2dc}, {to_ic, !to_ic});
    step();
    ack_mem = 1'b0;
    dat_mem = '0;
  endtask

  logic [31:0] exp3 [4] = '{32'h0000_1100, 32'h0000_2200, 32'h0000_1100, 32'h0000_2200};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    step();
    step();
    rst = 1'b0;

    // Single icache refill, one beat every other cycle.
    adr_ic = 32'hFF07_BD08;
    req_ic = 1'b1;
    @(negedge clk);
    check("t1_lat0", req_arb2mem, 1'b0);
    step();
    @(negedge clk);
    check("t1_req", req_arb2mem, 1'b1);
    check("t1_adr", adr_arb2mem, 32'hFF07_BD08);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_ic = 1'b0;
      ack_beat(32'hFFFF_FFFF, 2'(k), 1'b1);
      if (k < 3) step();
    end
    @(negedge clk);
    check("t1_req_fall", req_arb2mem, 1'b0);
    check("t1_busy_rel", busy, 1'b1);
    step();
    @(negedge clk);
    check("t1_busy_idle", busy, 1'b0);
    step();

    // Simultaneous requests straight out of reset: icache first.
    rst = 1'b1;
    step();
    rst = 1'b0;
    adr_ic = 32'hA555_2D0C;
    adr_dc = 32'h3C3C_0040;
    req_ic = 1'b1;
    req_dc = 1'b1;
    step();
    @(negedge clk);
    check("t2_first", adr_arb2mem, 32'hA555_2D0C);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_ic = 1'b0;
      ack_beat(32'h1000_0000 + k, 2'(k), 1'b1);
    end
    n = 1;
    while (!req_arb2mem && n < 10) begin
      step();
      n++;
    end
    check("t2_dc_gap", n, 3);
    check("t2_dc_adr", adr_arb2mem, 32'h3C3C_0040);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_dc = 1'b0;
      ack_beat(32'h2000_0000 + k, 2'(k), 1'b0);
    end
    step();

    // Continuous contention: owners alternate.
    adr_ic = 32'h0000_1100;
    adr_dc = 32'h0000_2200;
    req_ic = 1'b1;
    req_dc = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_grant("t3_grant");
      check("t3_owner", adr_arb2mem, exp3[b]);
      for (int k = 0; k < 4; k++) begin
        if (b == 3 && k == 3) begin
          req_ic = 1'b0;
          req_dc = 1'b0;
        end
        ack_beat(32'h3000_0000 + 32'(b * 16 + k), 2'(k), (b % 2) == 0);
      end
    end
    step();

    // Owner drops its request after beat 1; burst still completes.
    adr_ic = 32'h0000_7740;
    req_ic = 1'b1;
    wait_grant("t4_grant");
    ack_beat(32'h4000_0000, 2'd0, 1'b1);
    ack_beat(32'h4000_0001, 2'd1, 1'b1);
    req_ic = 1'b0;
    ack_beat(32'h4000_0002, 2'd2, 1'b1);
    ack_beat(32'h4000_0003, 2'd3, 1'b1);
    ack_mem = 1'b1;
    dat_mem = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_spur_ack", {ack_arb2ic, ack_arb2dc}, 2'b00);
    check("t4_spur_dat", {dat_arb2ic, dat_arb2dc}, 64'h0);
    check("t4_busy", busy, 1'b1);
    step();
    ack_mem = 1'b0;
    dat_mem = '0;

    // Reset in the middle of a dcache burst.
    adr_dc = 32'h0000_5580;
    req_dc = 1'b1;
    wait_grant("t5_grant");
    ack_beat(32'h5000_0000, 2'd0, 1'b0);
    ack_beat(32'h5000_0001, 2'd1, 1'b0);
    ack_beat(32'h5000_0002, 2'd2, 1'b0);
    rst     = 1'b1;
    req_dc  = 1'b0;
    ack_mem = 1'b1;
    dat_mem = 32'hCAFE_F00D;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_zero", {ack_arb2ic, dat_arb2ic, err_arb2ic, ack_arb2dc, dat_arb2dc, err_arb2dc,
                      word_arb2cc, req_arb2mem, adr_arb2mem, busy}, 128'h0);
    step();
    ack_mem = 1'b0;
    dat_mem = '0;
    adr_ic = 32'h0000_9900;
    req_ic = 1'b1;
    wait_grant("t5_regrant");
    check("t5_adr", adr_arb2mem, 32'h0000_9900);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_ic = 1'b0;
      ack_beat(32'h5100_0000 + k, 2'(k), 1'b1);
    end
    step();

    // Memory stalls after two beats of a dcache burst.
    adr_dc = 32'h0000_AA00;
    req_dc = 1'b1;
    wait_grant("t6_grant");
    ack_beat(32'h6000_0000, 2'd0, 1'b0);
    ack_beat(32'h6000_0001, 2'd1, 1'b0);
    req_dc = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    n = 1;
    forever begin
      @(negedge clk);
      if (err_arb2dc || n >= 100) break;
      step();
      n++;
    end
    check("t6_err_delay", n, TMO);
    check("t6_req_drop", req_arb2mem, 1'b0);
    check("t6_err_ic", err_arb2ic, 1'b0);
    step();
    ack_mem = 1'b1;
    dat_mem = 32'h6000_0002;
    @(negedge clk);
    check("t6_late_ack", ack_arb2dc, 1'b0);
    check("t6_err_once", err_arb2dc, 1'b0);
    step();
    ack_mem = 1'b0;
    dat_mem = '0;
`else
    repeat (80) step();
    @(negedge clk);
    check("t6_still_busy", {busy, req_arb2mem, err_arb2dc}, 3'b110);
    step();
    ack_beat(32'h6000_0002, 2'd2, 1'b0);
    ack_beat(32'h6000_0003, 2'd3, 1'b0);
`endif
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
